// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg
//   Shared constants for the EX-stage divider: operand and counter widths,
//   the 2-bit FSM state encodings, start/ready handshake levels, and the
//   DIV/DIVU aluop codes the EX stage decodes before raising start_i.
//   No ports; imported by ex_div_unit.
package ex_div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  // Divider FSM states
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Handshake levels
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Aluop codes that select this unit
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Multi-cycle restoring divider beside the EX stage, serving DIV/DIVU.
//   Produces {remainder, quotient} for HI/LO and requests a pipeline stall
//   while a division is outstanding.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed DIV, 0 = DIVU (sampled with start_i)
//   opdata1_i     dividend (sampled with start_i)
//   opdata2_i     divisor  (sampled with start_i)
//   start_i       division request, held until ready_o is seen
//   annul_i       cancel an in-flight division
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//   stallreq_o    start_i & ~ready_o (combinational)
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  logic [1:0]          state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [2*DATA_W:0]   work_q,     work_d;
  logic [DATA_W-1:0]   divisor_q,  divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q,  neg_rem_d;
  logic [2*DATA_W-1:0] result_q,   result_d;
  logic                ready_q,    ready_d;

  logic [DATA_W-1:0]   dividend_abs;
  logic [DATA_W-1:0]   divisor_abs;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // The core always divides magnitudes; signs are reapplied at the end.
  assign dividend_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign divisor_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Trial subtraction of the divisor from the current partial remainder;
  // the extra top bit is the borrow that tells whether the step restores.
  assign diff = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

  // Quotient bits are shifted in at the bottom; the remainder ends up one
  // bit above the original dividend field.
  assign quot     = work_q[DATA_W-1:0];
  assign rem      = work_q[2*DATA_W:DATA_W+1];
  assign quot_fix = neg_quot_q ? -quot : quot;
  assign rem_fix  = neg_rem_q  ? -rem  : rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            work_d     = {{DATA_W{1'b0}}, dividend_abs, 1'b0};
            divisor_d  = divisor_abs;
            neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end

      // Division by zero yields zero after one extra cycle, no trap.
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        // A flush always wins over the iteration step.
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q < CNT_W'(DATA_W)) begin
          if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      // Hold the result while EX is frozen by a later stall.
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: begin
        state_d = DivFree;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit
//   Self-checking bench for ex_div_unit: a table of directed divisions,
//   hand-written annul and asynchronous-reset sequences, and randomized
//   divisions compared against a plain-arithmetic reference.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    logic [7:0]  lat;
    logic [3:0]  hold;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  // Reference: truncating division, remainder takes the dividend's sign,
  // divide-by-zero gives zero, everything wraps to 32 bits.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input int exp_lat, input logic [63:0] exp_res,
                                input int hold_extra);
    int lat = 0;
    int stall_bad = 0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    #1;
    check_output({name, "_stall_rise"}, 64'(stallreq_o), 64'd1);
    while (ready_o !== 1'b1 && lat < 100) begin
      if (stallreq_o !== 1'b1) stall_bad++;
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    check_output({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check_output({name, "_stall_held"}, 64'(stall_bad), 64'd0);
    check_output({name, "_result"}, result_o, exp_res);
    check_output({name, "_stall_drop"}, 64'(stallreq_o), 64'd0);
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
      check_output({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      check_output({name, "_hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check_output({name, "_free_ready"}, 64'(ready_o), 64'd0);
    check_output({name, "_free_result"}, result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ready_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0] = '{32'd100,       32'd7,         1'b0, {32'd2,        32'd14},        8'd34, 4'd0};
    vecs[1] = '{32'hFFFFFFF9,  32'h2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},  8'd34, 4'd0};
    vecs[2] = '{32'h7,         32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD},  8'd34, 4'd0};
    vecs[3] = '{32'h1234,      32'h0,         1'b0, 64'd0,                         8'd2,  4'd0};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h00000000, 32'h80000000},  8'd34, 4'd3};
    vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, {32'd0,        32'd1},         8'd34, 4'd0};
    vecs[6] = '{32'd5,         32'd10,        1'b0, {32'd5,        32'd0},         8'd34, 4'd0};
    vecs[7] = '{32'hFFFFFFFF,  32'h2,         1'b1, {32'hFFFFFFFF, 32'h0},         8'd34, 4'd0};

    // Reset state, checked with no clock edge involved
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #2 rst = 1'b0;
    #1;
    check_output("reset_result", result_o, 64'd0);
    check_output("reset_ready", 64'(ready_o), 64'd0);
    check_output("reset_stall", 64'(stallreq_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                     int'(vecs[i].lat), vecs[i].exp, int'(vecs[i].hold));
    end

    // Annul after ten iterations, then a fresh division must work normally
    signed_div_i = 1'b0;
    opdata1_i    = 32'h12345678;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check_output("annul_ready", 64'(ready_o), 64'd0);
    check_output("annul_result", result_o, 64'd0);
    ready_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o === 1'b1) ready_seen++; end
    check_output("annul_no_ready", 64'(ready_seen), 64'd0);
    apply_stimulus("after_annul", 32'hFFFFFFFF, 32'd1, 1'b0, 34, {32'd0, 32'hFFFFFFFF}, 0);

    // Start together with annul in FREE must not launch a division
    opdata1_i = 32'd50;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    ready_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (ready_o === 1'b1) ready_seen++; end
    start_i = 1'b0;
    annul_i = 1'b0;
    check_output("start_annul_no_ready", 64'(ready_seen), 64'd0);

    // Asynchronous reset in the middle of the iteration
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd9;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (21) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check_output("rst_on_result", result_o, 64'd0);
    check_output("rst_on_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    ready_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o === 1'b1) ready_seen++; end
    check_output("rst_on_no_ready", 64'(ready_seen), 64'd0);

    // Asynchronous reset while a finished result is being held
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    ready_seen = 0;
    while (ready_o !== 1'b1 && ready_seen < 60) begin @(posedge clk); #1; ready_seen++; end
    check_output("rst_end_reached", result_o, {32'd2, 32'd14});
    #2 rst = 1'b0;
    #1;
    check_output("rst_end_result", result_o, 64'd0);
    check_output("rst_end_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Randomized divisions against the reference
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = $urandom_range(1, 1000);
      rs = 1'($urandom_range(0, 1));
      apply_stimulus($sformatf("rand%0d", n), ra, rb, rs, (rb == 32'd0) ? 2 : 34,
                     ref_div(ra, rb, rs), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Multi-cycle 32-bit integer divider instantiated beside the EX stage. It serves DIV/DIVU and writes a 64-bit {remainder, quotient} for HI/LO.
While a division is in flight it raises a stall request to the pipeline controller. The controller then freezes IF through EX; the ID/EX register holds, and EX/MEM receives a bubble.
It is the initiator side of the stall protocol that the pipeline registers obey.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W.
CNT_W, 6, iteration counter width; must be large enough to hold DATA_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start_i in FREE
opdata1_i  input  32  dividend; sampled with start_i in FREE
opdata2_i  input  32  divisor; sampled with start_i in FREE
start_i  input  1  EX requests a division; held high until ready_o is seen
annul_i  input  1  cancel an in-flight division (flush/exception)
result_o  output  64  {remainder[63:32], quotient[31:0]}, registered
ready_o  output  1  result valid, registered
stallreq_o  output  1  combinational: start_i & ~ready_o

Behaviour:
- Reset (rst=0, any state, any time):
  - state=FREE, counter=0, working register=0.
  - result_o=0, ready_o=0, effective immediately.
  - A division in progress is lost. After rst=1 the unit waits for a fresh start_i.
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - On an edge with start_i=1 and annul_i=0:
    - If opdata2_i==0, go to BYZERO.
    - Otherwise go to ON. Set counter=0. Load working register W (65 bits) = {32'b0, |dividend|, 1'b0}. Latch |divisor| and the signs.
    - |x| is the two's-complement negation when signed_div_i=1 and x[31]=1; otherwise x unchanged.
- BYZERO: next edge goes to END. Result = 0, no ready pulse is skipped. ready_o rises 2 edges after start is sampled.
- ON, while annul_i=1: next edge goes to FREE, result_o=0, ready_o=0. annul_i has priority over the iteration step.
- ON, when counter < 32, one restoring step per edge:
  - diff = {1'b0, W[63:32]} - {1'b0, divisor}, 33-bit.
  - If diff[32]=1: W <= {W[63:0], 1'b0}.
  - Else: W <= {diff[31:0], W[31:0], 1'b1}.
  - counter increments.
- ON, when counter==32:
  - q = W[31:0], r = W[64:33].
  - If signed and the signs differ, negate q. If signed and the dividend is negative, negate r.
  - result_o <= {r, q}, ready_o <= 1, go to END.
  - ready_o first reads 1 after the 34th rising edge counted from the edge that sampled start_i.
- END:
  - ready_o=1, result_o is held.
  - On an edge with start_i=0: go to FREE, ready_o<=0, result_o<=0.
  - While start_i=1: stay in END and hold. This case arises when EX itself is held by a later-stage stall.
- Arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, with no trap.
- start_i=1 and annul_i=1 in FREE: no start, stay in FREE.
- Operand changes after the start sample are ignored.
- stallreq_o is asserted the same cycle start_i rises. It drops in the cycle ready_o is 1.

Decomposition:
- Put the state encodings (DivFree, DivByZero, DivOn, DivEnd) in defines.v. Encode them as 2-bit.
- Also in defines.v: DivStart/DivStop, DivResultReady/DivResultNotReady, and the DIV/DIVU aluop codes.
- Single module. The restoring step is an inline expression; no sub-module is warranted.

Test Plan:
- Unsigned 100/7, start held → ready_o=1 after 34 edges, result_o={32'd2, 32'd14}; stallreq_o high for the preceding cycles; start_i drop → FREE, result_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x2) → q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 → q=0xFFFFFFFD, r=0x00000001.
- Divisor 0 (0x1234/0) → BYZERO then END, ready_o=1 after 2 edges, result_o=0.
- annul_i pulsed when counter=10 → FREE next edge, ready_o=0; a new 0xFFFFFFFF/1 unsigned then yields q=0xFFFFFFFF, r=0.
- rst=0 asynchronously mid-ON (counter=20) → outputs 0 immediately without a clock; after release, no ready_o until a new start.
- Signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}. start held 3 extra cycles in END → result stable, ready_o stays 1.
